// File: rtl/snn_ecg_pkg.sv
// Shared sizing, state encoding and class labels for the ECG SNN
// timestep sequencer and rate decoder.
package snn_ecg_pkg;

    localparam int SNN_N_IN    = 30;
    localparam int SNN_N_OUT   = 5;
    localparam int SNN_T_STEPS = 16;
    localparam int SNN_CNT_W   = 5;
    localparam int SNN_CLS_W   = 3;
    localparam int SNN_TIMEOUT = 1023;

    localparam int CLS_N = 0;
    localparam int CLS_S = 1;
    localparam int CLS_V = 2;
    localparam int CLS_F = 3;
    localparam int CLS_Q = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ACC    = 3'd2,
        ST_ARGMAX = 3'd3,
        ST_EMIT   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/snn_ecg_seq_decoder_argmax.sv
// Sequential argmax over a packed count vector: one class per cycle,
// strict-greater replacement so ties resolve to the lowest index.
module snn_argmax_seq #(
    parameter int N_OUT = 5,
    parameter int CNT_W = 5,
    parameter int CLS_W = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [N_OUT*CNT_W-1:0] counts,
    output logic                   busy,
    output logic                   done,
    output logic [CLS_W-1:0]       best_idx,
    output logic [CNT_W-1:0]       best_cnt
);

    logic             running_q;
    logic [CLS_W-1:0] idx_q;
    logic [CLS_W-1:0] bidx_q;
    logic [CNT_W-1:0] bcnt_q;

    logic             active;
    logic             last;
    logic             take;
    logic [CLS_W-1:0] cur_idx;
    logic [CNT_W-1:0] cur_cnt;

    // The start cycle scans class 0, so the result of the final class
    // is visible combinationally in the same cycle as done.
    always_comb begin
        active  = start | running_q;
        cur_idx = start ? '0 : idx_q;
        cur_cnt = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (cur_idx == CLS_W'(i)) begin
                cur_cnt = counts[i*CNT_W +: CNT_W];
            end
        end
        last     = (cur_idx == CLS_W'(N_OUT - 1));
        take     = start | (cur_cnt > bcnt_q);
        best_idx = take ? cur_idx : bidx_q;
        best_cnt = take ? cur_cnt : bcnt_q;
        done     = active & last;
    end

    assign busy = running_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_q <= 1'b0;
            idx_q     <= '0;
            bidx_q    <= '0;
            bcnt_q    <= '0;
        end else if (active) begin
            running_q <= ~last;
            idx_q     <= cur_idx + 1'b1;
            bidx_q    <= best_idx;
            bcnt_q    <= best_cnt;
        end
    end

endmodule

// File: rtl/snn_ecg_seq_decoder.sv
// Timestep sequencer and spike-rate decoder downstream of the ECG SNN
// core: drives one frame per timestep, counts class spikes, emits argmax.
module snn_ecg_seq_decoder
    import snn_ecg_pkg::*;
#(
    parameter int N_IN    = SNN_N_IN,
    parameter int N_OUT   = SNN_N_OUT,
    parameter int T_STEPS = SNN_T_STEPS,
    parameter int CNT_W   = SNN_CNT_W,
    parameter int CLS_W   = SNN_CLS_W,
    parameter int TIMEOUT = SNN_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_bits,
    output logic             net_start,
    output logic [N_IN-1:0]  net_spikes_in,
    input  logic             net_done,
    input  logic [N_OUT-1:0] net_spikes_out,
    output logic             cls_valid,
    output logic [CLS_W-1:0] cls_id,
    output logic [CNT_W-1:0] cls_count,
    output logic             cls_none,
    output logic             err_timeout,
    output logic             busy
);

    localparam int STEP_W = $clog2(T_STEPS + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    seq_state_t state_q;
    seq_state_t state_d;

    logic [TMO_W-1:0]       tmo_q;
    logic [STEP_W-1:0]      step_q;
    logic [N_OUT-1:0]       cap_q;
    logic [CNT_W-1:0]       cnt_q [N_OUT];
    logic                   start_q;
    logic [N_IN-1:0]        frame_q;
    logic                   err_q;
    logic [CLS_W-1:0]       cls_id_q;
    logic [CNT_W-1:0]       cls_cnt_q;
    logic                   cls_none_q;

    logic                   accept;
    logic                   tmo_hit;
    logic                   last_step;
    logic                   am_start;
    logic                   am_busy;
    logic                   am_done;
    logic [CLS_W-1:0]       am_idx;
    logic [CNT_W-1:0]       am_cnt;
    logic [N_OUT*CNT_W-1:0] counts_flat;

    assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT));
    assign last_step = (step_q == STEP_W'(T_STEPS - 1));

    always_comb begin
        counts_flat = '0;
        for (int i = 0; i < N_OUT; i++) begin
            counts_flat[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        cls_valid = 1'b0;
        accept    = 1'b0;
        am_start  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) state_d = ST_WAIT;
            end
            // A done arriving on the timeout cycle takes priority.
            ST_WAIT: begin
                if (net_done)     state_d = ST_ACC;
                else if (tmo_hit) state_d = ST_IDLE;
            end
            ST_ACC: begin
                state_d = last_step ? ST_ARGMAX : ST_IDLE;
            end
            ST_ARGMAX: begin
                am_start = ~am_busy;
                if (am_done) state_d = ST_EMIT;
            end
            ST_EMIT: begin
                cls_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q      <= '0;
            step_q     <= '0;
            cap_q      <= '0;
            start_q    <= 1'b0;
            frame_q    <= '0;
            err_q      <= 1'b0;
            cls_id_q   <= '0;
            cls_cnt_q  <= '0;
            cls_none_q <= 1'b0;
            for (int i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
        end else begin
            start_q <= accept;
            err_q   <= 1'b0;
            if (accept) frame_q <= in_bits;
            unique case (state_q)
                ST_IDLE: tmo_q <= '0;
                ST_WAIT: begin
                    if (net_done) begin
                        cap_q <= net_spikes_out;
                    end else if (tmo_hit) begin
                        err_q  <= 1'b1;
                        step_q <= '0;
                        for (int i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ST_ACC: begin
                    step_q <= step_q + 1'b1;
                    for (int i = 0; i < N_OUT; i++) begin
                        if (cap_q[i] && cnt_q[i] != '1) begin
                            cnt_q[i] <= cnt_q[i] + 1'b1;
                        end
                    end
                end
                // An empty window reports the normal-beat label.
                ST_ARGMAX: begin
                    if (am_done) begin
                        cls_none_q <= (am_cnt == '0);
                        cls_cnt_q  <= am_cnt;
                        cls_id_q   <= (am_cnt == '0) ? CLS_W'(CLS_N) : am_idx;
                    end
                end
                ST_EMIT: begin
                    step_q <= '0;
                    for (int i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
                end
                default: ;
            endcase
        end
    end

    snn_argmax_seq #(
        .N_OUT (N_OUT),
        .CNT_W (CNT_W),
        .CLS_W (CLS_W)
    ) u_argmax (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (am_start),
        .counts   (counts_flat),
        .busy     (am_busy),
        .done     (am_done),
        .best_idx (am_idx),
        .best_cnt (am_cnt)
    );

    assign net_start     = start_q;
    assign net_spikes_in = frame_q;
    assign err_timeout   = err_q;
    assign cls_id        = cls_id_q;
    assign cls_count     = cls_cnt_q;
    assign cls_none      = cls_none_q;
    assign busy          = (state_q != ST_IDLE) | (step_q != '0);

endmodule

// File: tb/tb_snn_ecg_seq_decoder.sv
// Randomized bench for the ECG SNN sequencer/decoder with a cycle-level
// behavioural model of the window protocol and class argmax.
module tb_snn_ecg_seq_decoder;
    import snn_ecg_pkg::*;

    localparam int N_IN    = SNN_N_IN;
    localparam int N_OUT   = SNN_N_OUT;
    localparam int CNT_W   = SNN_CNT_W;
    localparam int CLS_W   = SNN_CLS_W;
    localparam int T_STEPS = 4;
    localparam int TIMEOUT = 20;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int WIN_W   = T_STEPS * N_OUT;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N_IN-1:0]  in_bits = '0;
    logic             net_start;
    logic [N_IN-1:0]  net_spikes_in;
    logic             net_done = 1'b0;
    logic [N_OUT-1:0] net_spikes_out = '0;
    logic             cls_valid;
    logic [CLS_W-1:0] cls_id;
    logic [CNT_W-1:0] cls_count;
    logic             cls_none;
    logic             err_timeout;
    logic             busy;

    always #5 clk = ~clk;

    snn_ecg_seq_decoder #(
        .N_IN    (N_IN),
        .N_OUT   (N_OUT),
        .T_STEPS (T_STEPS),
        .CNT_W   (CNT_W),
        .CLS_W   (CLS_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_bits        (in_bits),
        .net_start      (net_start),
        .net_spikes_in  (net_spikes_in),
        .net_done       (net_done),
        .net_spikes_out (net_spikes_out),
        .cls_valid      (cls_valid),
        .cls_id         (cls_id),
        .cls_count      (cls_count),
        .cls_none       (cls_none),
        .err_timeout    (err_timeout),
        .busy           (busy)
    );

    int checks = 0;
    int errors = 0;

    logic             e_ready = 1'b1;
    logic             e_start = 1'b0;
    logic             e_valid = 1'b0;
    logic             e_err   = 1'b0;
    logic             e_busy  = 1'b0;
    logic             e_none  = 1'b0;
    logic [CLS_W-1:0] e_id    = '0;
    logic [CNT_W-1:0] e_cnt   = '0;
    logic [N_IN-1:0]  e_frame = '0;

    int mcnt [N_OUT];
    int msteps = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("in_ready", 32'(in_ready), 32'(e_ready));
        check("net_start", 32'(net_start), 32'(e_start));
        check("net_spikes_in", 32'(net_spikes_in), 32'(e_frame));
        check("cls_valid", 32'(cls_valid), 32'(e_valid));
        check("cls_id", 32'(cls_id), 32'(e_id));
        check("cls_count", 32'(cls_count), 32'(e_cnt));
        check("cls_none", 32'(cls_none), 32'(e_none));
        check("err_timeout", 32'(err_timeout), 32'(e_err));
        check("busy", 32'(busy), 32'(e_busy));
    end

    task automatic model_clear();
        for (int i = 0; i < N_OUT; i++) mcnt[i] = 0;
        msteps = 0;
    endtask

    task automatic model_emit();
        int best;
        best = 0;
        for (int i = 1; i < N_OUT; i++) begin
            if (mcnt[i] > mcnt[best]) best = i;
        end
        e_none  = (mcnt[best] == 0);
        e_id    = e_none ? '0 : CLS_W'(best);
        e_cnt   = CNT_W'(mcnt[best]);
        e_valid = 1'b1;
        model_clear();
    endtask

    task automatic tick(input logic rdy, input logic st, input logic bsy);
        @(posedge clk);
        #1;
        e_ready        = rdy;
        e_start        = st;
        e_busy         = bsy;
        e_valid        = 1'b0;
        e_err          = 1'b0;
        in_bits        = N_IN'($urandom);
        net_done       = 1'b0;
        net_spikes_out = N_OUT'($urandom);
    endtask

    task automatic idle(input int n, input logic spur);
        repeat (n) begin
            tick(1'b1, 1'b0, msteps != 0);
            in_valid = 1'b0;
            if (spur) net_done = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic step(input logic [N_OUT-1:0] sp, input int lat,
                        input logic hold);
        logic [N_IN-1:0] fr;
        fr = N_IN'($urandom);
        tick(1'b1, 1'b0, msteps != 0);
        in_valid = 1'b1;
        in_bits  = fr;
        tick(1'b0, 1'b1, 1'b1);
        e_frame  = fr;
        in_valid = hold;
        for (int i = 1; i <= lat; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            in_valid = hold;
            if (i == lat) begin
                net_done       = 1'b1;
                net_spikes_out = sp;
            end
        end
        tick(1'b0, 1'b0, 1'b1);
        in_valid = hold;
        net_done = 1'($urandom_range(0, 1));
        msteps++;
        for (int i = 0; i < N_OUT; i++) begin
            if (sp[i] && mcnt[i] < CNT_MAX) mcnt[i]++;
        end
        if (msteps == T_STEPS) begin
            repeat (N_OUT) begin
                tick(1'b0, 1'b0, 1'b1);
                in_valid = hold;
                net_done = 1'($urandom_range(0, 1));
            end
            tick(1'b0, 1'b0, 1'b1);
            in_valid = hold;
            model_emit();
        end
    endtask

    task automatic timeout_step(input logic spur);
        logic [N_IN-1:0] fr;
        fr = N_IN'($urandom);
        tick(1'b1, 1'b0, msteps != 0);
        in_valid = 1'b1;
        in_bits  = fr;
        tick(1'b0, 1'b1, 1'b1);
        e_frame  = fr;
        in_valid = 1'b0;
        repeat (TIMEOUT) begin
            tick(1'b0, 1'b0, 1'b1);
            in_valid = 1'b0;
        end
        model_clear();
        tick(1'b1, 1'b0, 1'b0);
        e_err    = 1'b1;
        in_valid = 1'b0;
        net_done = spur;
    endtask

    task automatic window(input logic [WIN_W-1:0] sp, input int lat,
                          input logic hold, input int lid,
                          input int lcnt, input int lnone);
        for (int s = 0; s < T_STEPS; s++) begin
            step(sp[s*N_OUT +: N_OUT], lat, hold);
        end
        if (lid >= 0) begin
            @(negedge clk);
            check("lit_cls_valid", 32'(cls_valid), 32'd1);
            check("lit_cls_id", 32'(cls_id), 32'(lid));
            check("lit_cls_count", 32'(cls_count), 32'(lcnt));
            check("lit_cls_none", 32'(cls_none), 32'(lnone));
        end
    endtask

    task automatic reset_mid();
        logic [N_IN-1:0] fr;
        step(5'b00001, 2, 1'b0);
        step(5'b00001, 2, 1'b0);
        fr = N_IN'($urandom);
        tick(1'b1, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_bits  = fr;
        tick(1'b0, 1'b1, 1'b1);
        e_frame  = fr;
        in_valid = 1'b0;
        tick(1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        tick(1'b1, 1'b0, 1'b0);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        e_id     = '0;
        e_cnt    = '0;
        e_none   = 1'b0;
        e_frame  = '0;
        model_clear();
        tick(1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        tick(1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2, 1'b0);

        window({4{5'b00100}}, 3, 1'b0, 2, 4, 0);
        idle(1, 1'b1);
        window({5'b00010, 5'b00011, 5'b00010, 5'b00011}, 3, 1'b0, 1, 4, 0);
        window({5'b00000, 5'b01010, 5'b01010, 5'b01010}, 2, 1'b1, 1, 3, 0);
        window({4{5'b00000}}, 1, 1'b0, 0, 0, 1);

        step(5'b00001, 3, 1'b0);
        step(5'b00001, 3, 1'b0);
        step(5'b00001, 3, 1'b0);
        timeout_step(1'b1);
        idle(1, 1'b0);
        window({5'b00000, 5'b00000, 5'b10000, 5'b10000}, 4, 1'b0, 4, 2, 0);

        window({4{5'b11111}}, TIMEOUT, 1'b1, 0, 4, 0);

        reset_mid();
        window({5'b00000, 5'b00000, 5'b00010, 5'b00010}, 3, 1'b0, 1, 2, 0);
        idle(2, 1'b1);

        for (int w = 0; w < 25; w++) begin
            logic [WIN_W-1:0] sp;
            int               lat;
            logic             hold;
            sp   = WIN_W'($urandom);
            lat  = ($urandom_range(0, 7) == 0) ? TIMEOUT
                                               : int'($urandom_range(1, 6));
            hold = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) begin
                step(sp[N_OUT-1:0], lat, hold);
                timeout_step(1'($urandom_range(0, 1)));
            end
            window(sp, lat, hold, -1, 0, 0);
            idle(int'($urandom_range(0, 2)), 1'b1);
        end

        idle(3, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
